// File: rtl/capture_wr_ctrl.sv
// capture_wr_ctrl: picks one lane out of a multi-lane ADC beat stream, decimates it and
// writes the kept words to a capture memory. An optional trigger can hold off the capture.
//
// Ports
//   clk, rst_n       single clock, asynchronous active-low reset
//   data_in          LANES*DATA_W ADC beat, lane k at [k*DATA_W +: DATA_W]
//   data_vld         data_in beat valid
//   cfg_lane_sel     lane to capture (out-of-range selects lane 0 and flags err_lane)
//   cfg_cap_len      number of words to capture, 0..2^ADDR_W
//   cfg_decim        keep 1 of every cfg_decim+1 candidate beats
//   cfg_trig_en      wait for trig before capturing
//   cap_start        start pulse (accepted in idle only)
//   cap_abort        abort pulse (wins over cap_start)
//   trig             capture trigger
//   mem_wr_en        memory write strobe
//   mem_wr_addr      memory write address
//   mem_wr_data      memory write data
//   cap_busy         waiting for trigger or capturing
//   cap_done         one-cycle completion pulse
//   cap_wr_cnt       words written in the current/last capture
//   err_lane         sticky illegal-lane flag, cleared on the next start
`timescale 1ns/1ps

module capture_wr_ctrl #(
    parameter int unsigned DATA_W = 96,
    parameter int unsigned LANES  = 9,
    parameter int unsigned ADDR_W = 12
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [LANES*DATA_W-1:0] data_in,
    input  logic                    data_vld,
    input  logic [3:0]              cfg_lane_sel,
    input  logic [ADDR_W:0]         cfg_cap_len,
    input  logic [3:0]              cfg_decim,
    input  logic                    cfg_trig_en,
    input  logic                    cap_start,
    input  logic                    cap_abort,
    input  logic                    trig,
    output logic                    mem_wr_en,
    output logic [ADDR_W-1:0]       mem_wr_addr,
    output logic [DATA_W-1:0]       mem_wr_data,
    output logic                    cap_busy,
    output logic                    cap_done,
    output logic [ADDR_W:0]         cap_wr_cnt,
    output logic                    err_lane
);

    localparam int unsigned CntW = ADDR_W + 1;

    typedef enum logic [1:0] {StIdle, StWaitTrig, StCapture, StDone} state_t;

    state_t              state_q, state_d;
    logic [3:0]          lane_q, lane_d;
    logic [ADDR_W:0]     len_q, len_d;
    logic [3:0]          decim_q, decim_d;
    logic [3:0]          dec_cnt_q, dec_cnt_d;
    logic [ADDR_W:0]     wr_cnt_q, wr_cnt_d;
    logic                err_q, err_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;

    logic [DATA_W-1:0]   lane_word;
    logic                lane_bad;
    logic                cand;
    logic [ADDR_W:0]     cnt_inc;

    // Lane mux; lane_q is always in range because bad selects are mapped to lane 0.
    always_comb begin
        lane_word = data_in[DATA_W-1:0];
        for (int unsigned k = 1; k < LANES; k++) begin
            if (lane_q == 4'(k)) begin
                lane_word = data_in[k*DATA_W +: DATA_W];
            end
        end
    end

    assign lane_bad = (32'(cfg_lane_sel) >= LANES);
    assign cnt_inc  = wr_cnt_q + CntW'(1);

    // A candidate beat is any valid beat while capturing, or the beat that arrives together
    // with the trigger. An abort in the same cycle kills it, so no write is left pending.
    assign cand = data_vld && !cap_abort &&
                  ((state_q == StCapture) || ((state_q == StWaitTrig) && trig));

    always_comb begin
        state_d   = state_q;
        lane_d    = lane_q;
        len_d     = len_q;
        decim_d   = decim_q;
        dec_cnt_d = dec_cnt_q;
        wr_cnt_d  = wr_cnt_q;
        err_d     = err_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;

        case (state_q)
            StIdle: begin
                if (cap_start && !cap_abort) begin
                    lane_d    = lane_bad ? 4'd0 : cfg_lane_sel;
                    err_d     = lane_bad;
                    len_d     = cfg_cap_len;
                    decim_d   = cfg_decim;
                    dec_cnt_d = 4'd0;
                    wr_cnt_d  = '0;
                    if (cfg_cap_len == '0) begin
                        state_d = StDone;
                    end else if (cfg_trig_en) begin
                        state_d = StWaitTrig;
                    end else begin
                        state_d = StCapture;
                    end
                end
            end
            StWaitTrig: begin
                if (cap_abort) begin
                    state_d = StIdle;
                end else if (trig) begin
                    state_d = StCapture;
                end
            end
            StCapture: begin
                if (cap_abort) begin
                    state_d = StIdle;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (cand) begin
            dec_cnt_d = (dec_cnt_q == decim_q) ? 4'd0 : dec_cnt_q + 4'd1;
            if (dec_cnt_q == 4'd0) begin
                wr_en_d   = 1'b1;
                wr_addr_d = wr_cnt_q[ADDR_W-1:0];
                wr_data_d = lane_word;
                wr_cnt_d  = cnt_inc;
                // Last write issued: leave capture now so no further beat can be kept.
                if (cnt_inc == len_q) begin
                    state_d = StDone;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            lane_q    <= 4'd0;
            len_q     <= '0;
            decim_q   <= 4'd0;
            dec_cnt_q <= 4'd0;
            wr_cnt_q  <= '0;
            err_q     <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            lane_q    <= lane_d;
            len_q     <= len_d;
            decim_q   <= decim_d;
            dec_cnt_q <= dec_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
            err_q     <= err_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign mem_wr_en   = wr_en_q;
    assign mem_wr_addr = wr_addr_q;
    assign mem_wr_data = wr_data_q;
    assign cap_busy    = (state_q == StWaitTrig) || (state_q == StCapture);
    assign cap_done    = (state_q == StDone);
    assign cap_wr_cnt  = wr_cnt_q;
    assign err_lane    = err_q;

endmodule

// File: doc/capture_wr_ctrl.md
CAPTURE_WR_CTRL -- requirements
Module: capture_wr_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 96, width of one ADC lane word.
REQ-002 SHALL have parameter LANES, default 9, number of ADC lanes on data_in.
REQ-003 SHALL have parameter ADDR_W, default 12, capture memory address width.
REQ-004 SHALL have port clk  in  1  single clock for all logic.
REQ-005 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have port data_in  in  LANES*DATA_W  ADC lanes; lane k occupies bits [k*DATA_W +: DATA_W].
REQ-007 SHALL have port data_vld  in  1  data_in beat valid.
REQ-008 SHALL have port cfg_lane_sel  in  4  lane to capture, legal 0..LANES-1.
REQ-009 SHALL have port cfg_cap_len  in  ADDR_W+1  words to capture, 0..2^ADDR_W.
REQ-010 SHALL have port cfg_decim  in  4  keep 1 of every cfg_decim+1 valid beats.
REQ-011 SHALL have port cfg_trig_en  in  1  1: wait for trig before capturing.
REQ-012 SHALL have port cap_start  in  1  single-cycle start pulse.
REQ-013 SHALL have port cap_abort  in  1  single-cycle abort pulse.
REQ-014 SHALL have port trig  in  1  external capture trigger, synchronous to clk.
REQ-015 SHALL have port mem_wr_en  out  1  memory write strobe.
REQ-016 SHALL have port mem_wr_addr  out  ADDR_W  memory write address.
REQ-017 SHALL have port mem_wr_data  out  DATA_W  memory write data.
REQ-018 SHALL have port cap_busy  out  1  high in WAIT_TRIG and CAPTURE.
REQ-019 SHALL have port cap_done  out  1  single-cycle pulse on completion.
REQ-020 SHALL have port cap_wr_cnt  out  ADDR_W+1  words written in current/last capture.
REQ-021 SHALL have port err_lane  out  1  sticky illegal-lane flag.

Function
REQ-022 SHALL implement states IDLE, WAIT_TRIG, CAPTURE, DONE.
REQ-023 SHALL, in IDLE on cap_start, latch all cfg_* inputs, clear cap_wr_cnt, decimation counter and err_lane, and enter WAIT_TRIG if cfg_trig_en=1, else CAPTURE.
REQ-024 SHALL, if latched cfg_cap_len=0, go directly IDLE->DONE on cap_start with no writes.
REQ-025 SHALL, if latched lane select >= LANES, set err_lane and capture lane 0.
REQ-026 SHALL move WAIT_TRIG->CAPTURE on trig=1; the data_vld beat coincident with trig is the first candidate beat.
REQ-027 SHALL treat a candidate beat as kept when the decimation counter is 0; counter increments per candidate beat and wraps from cfg_decim to 0.
REQ-028 SHALL, for each kept beat, assert mem_wr_en exactly one cycle later with mem_wr_data = selected lane and mem_wr_addr = cap_wr_cnt before increment.
REQ-029 SHALL increment cap_wr_cnt by 1 per write and enter DONE in the cycle the last write (count reaches cfg_cap_len) is issued.
REQ-030 SHALL pulse cap_done for exactly one cycle in DONE, then return to IDLE.
REQ-031 SHALL ignore cap_start outside IDLE; cfg_* changes during a capture SHALL have no effect.
REQ-032 SHALL, on cap_abort in WAIT_TRIG or CAPTURE, return to IDLE next cycle, suppress any pending write, hold cap_wr_cnt, and not pulse cap_done.
REQ-033 SHALL give cap_abort priority over cap_start when both are high in the same cycle.
REQ-034 SHALL ignore trig outside WAIT_TRIG and data_vld outside WAIT_TRIG/CAPTURE.
REQ-035 SHALL hold mem_wr_addr and mem_wr_data stable when mem_wr_en=0.
REQ-036 SHALL never write more than cfg_cap_len words; cfg_cap_len=2^ADDR_W fills all addresses, wrapping to 0 only after DONE.

Reset
REQ-037 SHALL, while rst_n=0, force state IDLE and all outputs and internal counters to 0.
REQ-038 SHALL, on reset mid-capture, discard the capture with no further writes and no cap_done pulse.

Verification
REQ-039 SHALL cover: lane 3, len 4, decim 0, trig_en 0, data_vld continuous -> 4 writes at addr 0..3 with lane-3 data, cap_done 1 cycle after 4th write issue, cap_wr_cnt=4.
REQ-040 SHALL cover: decim 2, len 3, 9 valid beats -> beats 0, 3, 6 written at addr 0, 1, 2.
REQ-041 SHALL cover: trig_en 1, trig on beat 5 -> first write carries beat 5 data, none before.
REQ-042 SHALL cover: abort after 2 writes of len 8 -> no further mem_wr_en, cap_wr_cnt=2, cap_done never pulses.
REQ-043 SHALL cover: lane_sel 12 -> err_lane=1, lane-0 data written; next cap_start clears err_lane.
REQ-044 SHALL cover: len 0 -> cap_done pulses with zero writes; rst_n low mid-capture -> outputs 0, state IDLE.
